// File: rtl/rf_host_arbiter_pkg.sv
// Shared definitions for the register-file host/pipeline arbiter.
// State encoding, default widths and wait-counter width.
package rf_host_arbiter_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 4;
    localparam int CNT_W      = 8;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_FORCE = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

endpackage

// File: rtl/rf_host_arbiter_port_mux.sv
// Register-file port steering between pipeline and host.
// Pure combinational; grants come from the arbiter FSM.
module rf_host_arbiter_port_mux #(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 4
) (
    input  logic              host_wr_gnt,
    input  logic              host_rd_gnt,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic [ADDR_W-1:0] pipe_r0addr,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_r0addr
);

    // Host takes a port only in its granted cycle; otherwise pipeline passes through
    always_comb begin
        rf_wena   = wb_en;
        rf_waddr  = wb_addr;
        rf_wdata  = wb_data;
        rf_r0addr = pipe_r0addr;
        if (host_wr_gnt) begin
            rf_wena  = 1'b1;
            rf_waddr = cmd_addr;
            rf_wdata = cmd_wdata;
        end
        if (host_rd_gnt) begin
            rf_r0addr = cmd_addr;
        end
    end

endmodule

// File: rtl/rf_host_arbiter.sv
// Shares the RF write port and read port 0 between pipeline and host.
// Pipeline has priority; a starvation counter forces a one-cycle stall.
module rf_host_arbiter
    import rf_host_arbiter_pkg::*;
#(
    parameter int DATA_W       = DATA_W_DEF,
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              pipe_rd_active,
    input  logic [ADDR_W-1:0] pipe_r0addr,
    output logic              pipe_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ack,
    output logic [DATA_W-1:0] host_rdata,
    output logic              host_busy,
    output logic              proto_err,
    output logic              rf_wena,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_r0addr,
    input  logic [DATA_W-1:0] rf_r0data
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(STARVE_LIMIT - 1);

    logic [1:0]        state_q, state_d;
    logic              cmd_we_q, cmd_we_d;
    logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
    logic [DATA_W-1:0] cmd_wdata_q, cmd_wdata_d;
    logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              proto_err_q, proto_err_d;

    logic in_wait;
    logic in_force;
    logic slot_free;
    logic grant;
    logic wr_gnt;
    logic rd_gnt;

    assign in_wait   = (state_q == ST_WAIT);
    assign in_force  = (state_q == ST_FORCE);
    assign slot_free = cmd_we_q ? ~wb_en : ~pipe_rd_active;
    assign grant     = (in_wait & slot_free) | in_force;
    // A pipeline write that ignores the stall keeps the port
    assign wr_gnt    = grant & cmd_we_q & ~wb_en;
    assign rd_gnt    = grant & ~cmd_we_q;

    assign pipe_stall = in_force;
    assign host_ack   = (state_q == ST_ACK);
    assign host_busy  = (state_q != ST_IDLE);
    assign host_rdata = host_rdata_q;
    assign proto_err  = proto_err_q;

    rf_host_arbiter_port_mux #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mux (
        .host_wr_gnt (wr_gnt),
        .host_rd_gnt (rd_gnt),
        .cmd_addr    (cmd_addr_q),
        .cmd_wdata   (cmd_wdata_q),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .pipe_r0addr (pipe_r0addr),
        .rf_wena     (rf_wena),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .rf_r0addr   (rf_r0addr)
    );

    // Command latch, wait counting and state sequencing
    always_comb begin
        state_d     = state_q;
        cmd_we_d    = cmd_we_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        wait_cnt_d  = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (host_req) begin
                    cmd_we_d    = host_we;
                    cmd_addr_d  = host_addr;
                    cmd_wdata_d = host_wdata;
                    wait_cnt_d  = '0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (slot_free) begin
                    state_d = ST_ACK;
                end else if (wait_cnt_q == LAST_WAIT) begin
                    state_d = ST_FORCE;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ST_FORCE: state_d = ST_ACK;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Read capture at grant (x0 reads as zero) and sticky contract error
    always_comb begin
        host_rdata_d = host_rdata_q;
        if (rd_gnt) begin
            host_rdata_d = (cmd_addr_q == '0) ? '0 : rf_r0data;
        end
        proto_err_d = proto_err_q | (in_force & (wb_en | pipe_rd_active));
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cmd_we_q     <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_wdata_q  <= '0;
            wait_cnt_q   <= '0;
            host_rdata_q <= '0;
            proto_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_we_q     <= cmd_we_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_wdata_q  <= cmd_wdata_d;
            wait_cnt_q   <= wait_cnt_d;
            host_rdata_q <= host_rdata_d;
            proto_err_q  <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_rf_host_arbiter.sv
// Scoreboard bench for rf_host_arbiter with a register-file model.
// Expected host results come from a transaction-level reference model.
module tb_rf_host_arbiter;

    localparam int DW = 64;
    localparam int AW = 4;
    localparam int SL = 8;
    localparam int NP = SL + 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          pipe_rd_active;
    logic [AW-1:0] pipe_r0addr;
    logic          pipe_stall;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          host_busy;
    logic          proto_err;
    logic          rf_wena;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic [AW-1:0] rf_r0addr;
    logic [DW-1:0] rf_r0data;

    rf_host_arbiter #(
        .DATA_W       (DW),
        .ADDR_W       (AW),
        .STARVE_LIMIT (SL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wb_en          (wb_en),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data),
        .pipe_rd_active (pipe_rd_active),
        .pipe_r0addr    (pipe_r0addr),
        .pipe_stall     (pipe_stall),
        .host_req       (host_req),
        .host_we        (host_we),
        .host_addr      (host_addr),
        .host_wdata     (host_wdata),
        .host_ack       (host_ack),
        .host_rdata     (host_rdata),
        .host_busy      (host_busy),
        .proto_err      (proto_err),
        .rf_wena        (rf_wena),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .rf_r0addr      (rf_r0addr),
        .rf_r0data      (rf_r0data)
    );

    always #5 clk = ~clk;

    // Register file: x0 hardwired, write-through forwarding on read port 0
    logic [DW-1:0] regs [16];
    always @(posedge clk) begin
        if (rf_wena && rf_waddr != '0) regs[rf_waddr] <= rf_wdata;
    end
    always_comb begin
        rf_r0data = '0;
        if (rf_r0addr != '0) begin
            if (rf_wena && rf_waddr == rf_r0addr) rf_r0data = rf_wdata;
            else rf_r0data = regs[rf_r0addr];
        end
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        bit          rd;
        logic [63:0] data;
        int          stalls;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [DW-1:0] arch [16];
    logic [DW-1:0] last_rd;
    bit            exp_busy;
    bit            exp_proto;
    bit            g_rd;
    bit            g_wr;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_data;
    int            stall_cnt;

    // Pipeline stimulus for one transaction window
    bit            p_wb [NP];
    logic [AW-1:0] p_wa [NP];
    logic [DW-1:0] p_wd [NP];
    bit            p_rd [NP];
    logic [AW-1:0] p_ra [NP];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: port steering every cycle, scoreboard pop on host_ack
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_cnt = 0;
        end else begin
            if (pipe_stall) stall_cnt++;
            chk("host_busy", 64'(host_busy), 64'(exp_busy));
            chk("proto_err", 64'(proto_err), 64'(exp_proto));
            if (g_wr) begin
                chk("host_wena", 64'(rf_wena), 64'd1);
                chk("host_waddr", 64'(rf_waddr), 64'(g_addr));
                chk("host_wdata", rf_wdata, g_data);
            end else begin
                chk("pipe_wena", 64'(rf_wena), 64'(wb_en));
                if (wb_en) begin
                    chk("pipe_waddr", 64'(rf_waddr), 64'(wb_addr));
                    chk("pipe_wdata", rf_wdata, wb_data);
                end
            end
            if (g_rd) chk("host_r0addr", 64'(rf_r0addr), 64'(g_addr));
            else chk("pipe_r0addr", 64'(rf_r0addr), 64'(pipe_r0addr));
            if (host_ack) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: got ack expected none (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                    chk("stall_cycles", 64'(stall_cnt), 64'(e.stalls));
                    chk(e.rd ? "read_data" : "rdata_hold", host_rdata, e.data);
                end
                stall_cnt = 0;
            end
        end
    end

    task automatic gen_pattern(input int mode);
        for (int j = 0; j < NP; j++) begin
            p_wa[j] = AW'($urandom);
            p_ra[j] = AW'($urandom);
            p_wd[j] = {$urandom, $urandom};
            case (mode)
                1: begin p_wb[j] = 1'b1; p_rd[j] = 1'b1; end
                2: begin p_wb[j] = 1'b0; p_rd[j] = 1'b0; end
                default: begin
                    p_wb[j] = ($urandom_range(0, 9) < 7);
                    p_rd[j] = ($urandom_range(0, 9) < 7);
                end
            endcase
        end
    endtask

    task automatic drive_pipe(input int j);
        wb_en          = p_wb[j];
        wb_addr        = p_wa[j];
        wb_data        = p_wd[j];
        pipe_rd_active = p_rd[j];
        pipe_r0addr    = p_ra[j];
    endtask

    task automatic model_pipe_wr(input int j);
        if (p_wb[j] && p_wa[j] != '0) arch[p_wa[j]] = p_wd[j];
    endtask

    // One host transaction: cycle 0 latch, grant at first free slot or forced
    task automatic run_txn(input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit viol);
        int          k;
        bit          vp;
        int unsigned base;
        exp_t        e;
        vp = 1'b0;
        base = 0;
        if (!viol) begin
            p_wb[SL+1] = 1'b0;
            p_rd[SL+1] = 1'b0;
        end
        k = SL + 1;
        for (int j = SL; j >= 1; j--) begin
            if (we ? !p_wb[j] : !p_rd[j]) k = j;
        end
        for (int j = 0; j <= k + 1; j++) begin
            @(posedge clk);
            #1;
            if (j == 0) begin
                base       = cyc;
                host_req   = 1'b1;
                host_we    = we;
                host_addr  = a;
                host_wdata = d;
                exp_busy   = 1'b0;
            end else begin
                host_we    = 1'($urandom);
                host_addr  = AW'($urandom);
                host_wdata = {$urandom, $urandom};
                exp_busy   = 1'b1;
            end
            drive_pipe(j);
            g_rd = 1'b0;
            g_wr = 1'b0;
            if (j == k) begin
                e.cyc    = base + k + 1;
                e.rd     = !we;
                e.stalls = (k == SL + 1) ? 1 : 0;
                if (!we) begin
                    if (a == '0) e.data = '0;
                    else if (p_wb[j] && p_wa[j] == a) e.data = p_wd[j];
                    else e.data = arch[a];
                    last_rd = e.data;
                end else begin
                    e.data = last_rd;
                end
                g_addr = a;
                g_data = d;
                g_rd   = !we;
                g_wr   = we && !p_wb[j];
                if (k == SL + 1 && (p_wb[j] || p_rd[j])) vp = 1'b1;
                if (g_wr && a != '0) arch[a] = d;
                sb.push_back(e);
            end
            if (j == k + 1 && vp) exp_proto = 1'b1;
            model_pipe_wr(j);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            gen_pattern(0);
            @(posedge clk);
            #1;
            host_req = 1'b0;
            exp_busy = 1'b0;
            g_rd     = 1'b0;
            g_wr     = 1'b0;
            drive_pipe(0);
            model_pipe_wr(0);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_busy", 64'(host_busy), 64'd0);
        chk("rst_stall", 64'(pipe_stall), 64'd0);
        chk("rst_ack", 64'(host_ack), 64'd0);
        chk("rst_proto", 64'(proto_err), 64'd0);
        chk("rst_rdata", host_rdata, 64'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        wb_en          = 1'b0;
        pipe_rd_active = 1'b0;
        host_req       = 1'b0;
        g_rd           = 1'b0;
        g_wr           = 1'b0;
        exp_busy       = 1'b0;
        exp_proto      = 1'b0;
        rst_n          = 1'b0;
        #2;
        check_reset_state();
        last_rd = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            regs[i] = '0;
            arch[i] = '0;
        end
        last_rd        = '0;
        exp_busy       = 1'b0;
        exp_proto      = 1'b0;
        g_rd           = 1'b0;
        g_wr           = 1'b0;
        g_addr         = '0;
        g_data         = '0;
        stall_cnt      = 0;
        wb_en          = 1'b0;
        wb_addr        = '0;
        wb_data        = '0;
        pipe_rd_active = 1'b0;
        pipe_r0addr    = '0;
        host_req       = 1'b0;
        host_we        = 1'b0;
        host_addr      = '0;
        host_wdata     = '0;
        rst_n          = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state();
        rst_n = 1'b1;

        // Idle pipeline: write 5 then read it back
        gen_pattern(2);
        run_txn(1'b1, 4'd5, 64'h1234, 1'b0);
        gen_pattern(2);
        run_txn(1'b0, 4'd5, 64'h0, 1'b0);

        // Writeback saturated: forced stall then ack
        gen_pattern(1);
        run_txn(1'b1, 4'd3, 64'hDEAD_BEEF, 1'b0);

        // Read 3 with pipeline reads 1,1,0
        gen_pattern(2);
        p_rd[1] = 1'b1;
        p_rd[2] = 1'b1;
        run_txn(1'b0, 4'd3, 64'h0, 1'b0);

        // Read 7 during writeback to 7: forwarded value
        gen_pattern(2);
        p_wb[1] = 1'b1;
        p_wa[1] = 4'd7;
        p_wd[1] = 64'hABCD;
        run_txn(1'b0, 4'd7, 64'h0, 1'b0);

        // Address 0 write is discarded, read returns zero
        gen_pattern(2);
        run_txn(1'b1, 4'd0, 64'hFFFF, 1'b0);
        gen_pattern(2);
        run_txn(1'b0, 4'd0, 64'h0, 1'b0);

        // Reset while waiting drops the command
        gen_pattern(1);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            host_req   = (j == 0);
            host_we    = 1'b1;
            host_addr  = 4'd9;
            host_wdata = 64'h5555;
            exp_busy   = (j != 0);
            drive_pipe(j);
            model_pipe_wr(j);
        end
        do_reset();
        gen_pattern(2);
        run_txn(1'b0, 4'd9, 64'h0, 1'b0);

        // Randomised traffic
        for (int t = 0; t < 200; t++) begin
            int m;
            m = $urandom_range(0, 9);
            gen_pattern(m < 6 ? 0 : (m < 8 ? 1 : 2));
            run_txn(1'($urandom), AW'($urandom), {$urandom, $urandom}, 1'b0);
            idle_cycles($urandom_range(0, 2));
        end

        // Contract violations in FORCE: sticky error until reset
        gen_pattern(1);
        run_txn(1'b1, 4'd6, 64'h6666, 1'b1);
        idle_cycles(3);
        gen_pattern(1);
        run_txn(1'b0, 4'd6, 64'h0, 1'b1);
        idle_cycles(2);
        do_reset();
        idle_cycles(2);

        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL missing_ack: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
